zmaps_wq: RTL



---
 rtl/zmaps_wq_pkg.sv | 24 ++
 rtl/zmaps_wq_fifo.sv | 52 +++++
 rtl/zmaps_wq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/zmaps_wq_pkg.sv
// Shared definitions for the Z80 memory-window mapper: slot encodings,
// file-to-slot mapping and queue entry sizing.
package zmaps_wq_pkg;

   localparam logic [2:0] SLOT_CRAM = 3'd0;
   localparam logic [2:0] SLOT_SFIL = 3'd1;
   localparam logic [2:0] SLOT_REGS = 3'd2;
   localparam logic [3:0] REGS_HI   = 4'b0100;   // a[11:8] of the register area

   localparam int WADDR_W = 8;
   localparam int WDATA_W = 16;

   // Queue entry layout: {file index, word address, word data}
   function automatic int entry_w(input int nfile);
      return $clog2(nfile) + WADDR_W + WDATA_W;
   endfunction

   // Files 0/1 sit in slots 0/1; the register area owns slot 2, so later
   // files are shifted up by one slot.
   function automatic logic [2:0] file_slot(input int f);
      return (f < 2) ? 3'(f) : 3'(f + 1);
   endfunction

endpackage

// File: rtl/zmaps_wq_fifo.sv
// Synchronous FIFO for posted CPU words. A push while full is accepted
// only when a pop happens in the same cycle.
module zmaps_wq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 25
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign dout_o  = mem_q[rd_ptr_q];

   // Storage array; contents are don't-care while empty, so no reset
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   // Pointers and occupancy count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/zmaps_wq.sv
// Z80 window decode, per-file byte pairing, posted-write queue and a
// single registered write port shared with DMA.
module zmaps_wq
   import zmaps_wq_pkg::*;
#(
   parameter int NFILE  = 2,
   parameter int FIFO_D = 4,
   parameter int STARVE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             memwr_s,
   input  logic [15:0]      a,
   input  logic [7:0]       d,
   input  logic [4:0]       fmaddr,
   input  logic [NFILE-1:0] dma_we,
   input  logic [7:0]       dma_wraddr,
   input  logic [15:0]      dma_data,
   output logic             dma_rdy,
   output logic [NFILE-1:0] we,
   output logic [7:0]       zma,
   output logic [15:0]      zmd,
   output logic             regs_we,
   output logic             ovf
);

   localparam int FW = $clog2(NFILE);
   localparam int EW = entry_w(NFILE);
   localparam int SW = $clog2(STARVE + 2);
   localparam logic [SW-1:0] ST_MAX = SW'(STARVE);

   logic             hit, fhit, commit;
   logic [NFILE-1:0] fsel;
   logic [FW-1:0]    fidx;
   logic [7:0]       lo_sel;
   logic [7:0]       lo_q [NFILE];
   logic [EW-1:0]    cpu_ent, q_head, cpu_src;
   logic             q_push, q_pop, q_full, q_empty;
   logic             forced, dma_acc, bypass, ovf_set;
   logic [NFILE-1:0] we_d, we_q;
   logic [7:0]       zma_d, zma_q;
   logic [15:0]      zmd_d, zmd_q;
   logic             ovf_q;
   logic [SW-1:0]    st_d, st_q;

   // Window hit and per-file slot decode
   always_comb begin
      hit    = memwr_s && fmaddr[4] && (a[15:12] == fmaddr[3:0]);
      fsel   = '0;
      fidx   = '0;
      lo_sel = '0;
      for (int f = 0; f < NFILE; f++) begin
         if (hit && (a[11:9] == file_slot(f))) begin
            fsel[f] = 1'b1;
            fidx    = FW'(f);
            lo_sel  = lo_q[f];
         end
      end
   end

   assign fhit    = |fsel;
   assign commit  = fhit && a[0];
   assign regs_we = hit && (a[11:8] == REGS_HI);
   assign cpu_ent = {fidx, a[8:1], d, lo_sel};

   // Per-file lower-byte latches; odd writes reuse whatever is latched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int f = 0; f < NFILE; f++) lo_q[f] <= '0;
      end else begin
         for (int f = 0; f < NFILE; f++)
            if (fsel[f] && !a[0]) lo_q[f] <= d;
      end
   end

   zmaps_wq_fifo #(
      .DEPTH (FIFO_D),
      .W     (EW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (q_push),
      .pop_i   (q_pop),
      .din_i   (cpu_ent),
      .dout_o  (q_head),
      .full_o  (q_full),
      .empty_o (q_empty)
   );

   // Write-port arbitration: forced CPU > DMA > queue head > bypass
   always_comb begin
      forced  = !q_empty && (STARVE != 0) && (st_q == ST_MAX);
      dma_rdy = !forced;
      dma_acc = (dma_we != '0) && !forced;
      q_pop   = 1'b0;
      bypass  = 1'b0;
      if (forced) begin
         q_pop = 1'b1;
      end else if (!dma_acc) begin
         if (!q_empty)    q_pop  = 1'b1;
         else if (commit) bypass = 1'b1;
      end
      cpu_src = bypass ? cpu_ent : q_head;

      we_d  = '0;
      zma_d = zma_q;
      zmd_d = zmd_q;
      if (dma_acc) begin
         we_d  = dma_we;
         zma_d = dma_wraddr;
         zmd_d = dma_data;
      end else if (q_pop || bypass) begin
         we_d  = NFILE'(1) << cpu_src[EW-1 -: FW];
         zma_d = cpu_src[23:16];
         zmd_d = cpu_src[15:0];
      end

      // A commit that did not bypass is posted; drops only when no room frees up
      q_push  = commit && !bypass;
      ovf_set = q_push && q_full && !q_pop;

      st_d = st_q;
      if (q_pop || bypass || q_empty)       st_d = '0;
      else if (dma_acc && (st_q != ST_MAX)) st_d = st_q + 1'b1;
   end

   // Output register, sticky overflow and starvation counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q  <= '0;
         zma_q <= '0;
         zmd_q <= '0;
         ovf_q <= 1'b0;
         st_q  <= '0;
      end else begin
         we_q  <= we_d;
         zma_q <= zma_d;
         zmd_q <= zmd_d;
         ovf_q <= ovf_q | ovf_set;
         st_q  <= st_d;
      end
   end

   assign we  = we_q;
   assign zma = zma_q;
   assign zmd = zmd_q;
   assign ovf = ovf_q;

endmodule
